// File: rtl/fila_leitor.sv
// Queue reader: issues single-cycle dequeue requests, waits out the queue latency and
// hands captured words downstream on valid/ready. Define FILA_LEITOR_PREFETCH_EN for a two-entry output buffer.
module fila_leitor #(
  parameter int DATA_LAT = 2,
  parameter int HOLDOFF  = 5
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic [7:0] len_in,
  input  logic [7:0] data_in,
  input  logic       enable_in,
  input  logic       ready_in,
  output logic       dequeue_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       busy_out,
  output logic [7:0] words_read
);

  localparam int CW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    words_read_reg;
  logic          capture;
  logic          transfer;
  logic          slot_free;

  // The queue's word is only valid in the WAIT cycle where cnt reaches DATA_LAT.
  assign capture = (state_reg == WAIT) && (cnt_reg == CW'(DATA_LAT));

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (enable_in && (len_in != 8'd0) && slot_free) begin
          state_next = REQ;
        end
      end
      REQ: begin
        cnt_next   = CW'(1);
        state_next = WAIT;
      end
      WAIT: begin
        // len_in is stale until HOLDOFF cycles after the request
        if (cnt_reg == CW'(HOLDOFF - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      words_read_reg <= 8'd0;
    end else if (capture) begin
      words_read_reg <= words_read_reg + 8'd1;
    end
  end

  assign dequeue_out = (state_reg == REQ);
  assign busy_out    = (state_reg != IDLE);
  assign words_read  = words_read_reg;

`ifdef FILA_LEITOR_PREFETCH_EN

  // Entry 0 is the older word and drives data_out; entry 1 queues behind it.
  logic [1:0][7:0] buf_data_reg, buf_data_next;
  logic [1:0]      buf_valid_reg, buf_valid_next;

  assign slot_free = !buf_valid_reg[1];
  assign transfer  = buf_valid_reg[0] && ready_in;

  always_comb begin
    buf_data_next  = buf_data_reg;
    buf_valid_next = buf_valid_reg;
    if (transfer) begin
      if (buf_valid_reg[1]) begin
        buf_data_next[0] = buf_data_reg[1];
      end
      buf_valid_next = {1'b0, buf_valid_reg[1]};
    end
    // A capture lands in the first entry left free after any same-edge transfer.
    if (capture) begin
      if (!buf_valid_next[0]) begin
        buf_data_next[0]  = data_in;
        buf_valid_next[0] = 1'b1;
      end else begin
        buf_data_next[1]  = data_in;
        buf_valid_next[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      buf_data_reg  <= '0;
      buf_valid_reg <= 2'b00;
    end else begin
      buf_data_reg  <= buf_data_next;
      buf_valid_reg <= buf_valid_next;
    end
  end

  assign data_out  = buf_data_reg[0];
  assign valid_out = buf_valid_reg[0];

`else

  logic [7:0] slot_data_reg;
  logic       slot_valid_reg;

  assign slot_free = !slot_valid_reg;
  assign transfer  = slot_valid_reg && ready_in;

  // Capture wins over transfer: the new word replaces the one just taken.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      slot_data_reg  <= 8'h00;
      slot_valid_reg <= 1'b0;
    end else if (capture) begin
      slot_data_reg  <= data_in;
      slot_valid_reg <= 1'b1;
    end else if (transfer) begin
      slot_valid_reg <= 1'b0;
    end
  end

  assign data_out  = slot_data_reg;
  assign valid_out = slot_valid_reg;

`endif

endmodule

// File: tb/tb_fila_leitor.sv
// Self-checking bench for fila_leitor: behavioural queue model plus a transfer scoreboard.
module tb_fila_leitor;

  localparam int DATA_LAT = 2;
  localparam int HOLDOFF  = 5;

  logic       clk_10KHz = 1'b0;
  logic       reset;
  logic [7:0] len_in;
  logic [7:0] data_in;
  logic       enable_in;
  logic       ready_in;
  logic       dequeue_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       busy_out;
  logic [7:0] words_read;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] qmem[$];
  logic [7:0] exp_q[$];
  int         req_cyc[$];
  int         req_count = 0;
  int         cyc_cnt   = 0;
  int         age       = -1;

  fila_leitor #(
    .DATA_LAT(DATA_LAT),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk_10KHz  (clk_10KHz),
    .reset      (reset),
    .len_in     (len_in),
    .data_in    (data_in),
    .enable_in  (enable_in),
    .ready_in   (ready_in),
    .dequeue_out(dequeue_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .busy_out   (busy_out),
    .words_read (words_read)
  );

  always #5 clk_10KHz = ~clk_10KHz;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue model: head word appears DATA_LAT edges after the request, length drops after HOLDOFF.
  always @(negedge clk_10KHz) begin
    if (!reset && dequeue_out) begin
      req_count++;
      req_cyc.push_back(cyc_cnt);
      age = 0;
    end
  end

  always @(posedge clk_10KHz) begin
    #1;
    cyc_cnt++;
    if (reset) begin
      age     = -1;
      data_in = 8'h00;
    end else if (age >= 0) begin
      age++;
      if (age == DATA_LAT) begin
        if (qmem.size() > 0) data_in = qmem.pop_front();
        else data_in = 8'hEE;
      end else if (age == DATA_LAT + 1) begin
        data_in = 8'hEE;
      end
      if (age == HOLDOFF) begin
        if (len_in != 8'd0) len_in = len_in - 8'd1;
        age = -1;
      end
    end
  end

  // Scoreboard: every accepted word must be the next one loaded into the queue.
  always @(negedge clk_10KHz) begin
    if (!reset && valid_out && ready_in) begin
      $display("xfer data=%02h words_read=%0d t=%0t", data_out, words_read, $time);
      if (exp_q.size() == 0) check("xfer_unexpected", 32'(data_out), 32'h100);
      else check("xfer_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic adv(int n);
    repeat (n) begin
      @(posedge clk_10KHz);
      #2;
    end
  endtask

  task automatic load(logic [7:0] w);
    qmem.push_back(w);
    exp_q.push_back(w);
    len_in = len_in + 8'd1;
  endtask

  task automatic wait_drain(string tag, int budget);
    int n;
    n = 0;
    while (!(len_in == 8'd0 && !busy_out && !valid_out && exp_q.size() == 0) && n < budget) begin
      adv(1);
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  initial begin
    int base;
    int d;

    reset     = 1'b1;
    len_in    = 8'd0;
    data_in   = 8'h00;
    enable_in = 1'b0;
    ready_in  = 1'b0;
    #1;
    check("rst_dequeue", 32'(dequeue_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_words", 32'(words_read), 0);
    adv(3);
    reset = 1'b0;

    // Empty queue: never request
    enable_in = 1'b1;
    base = req_count;
    adv(20);
    check("empty_reqs", req_count - base, 0);
    check("empty_busy", 32'(busy_out), 0);
    check("empty_words", 32'(words_read), 0);

    // Single word, downstream stalled
    ready_in = 1'b0;
    base = req_count;
    load(8'hA5);
    adv(1);
    check("one_c0_deq", 32'(dequeue_out), 1);
    adv(1);
    check("one_c1_deq", 32'(dequeue_out), 0);
    check("one_c1_busy", 32'(busy_out), 1);
    adv(1);
    check("one_c2_valid", 32'(valid_out), 0);
    adv(1);
    check("one_c3_valid", 32'(valid_out), 1);
    check("one_c3_data", 32'(data_out), 32'h A5);
    check("one_c3_words", 32'(words_read), 1);
    adv(1);
    check("one_c4_busy", 32'(busy_out), 1);
    adv(1);
    check("one_c5_busy", 32'(busy_out), 0);
    adv(15);
    check("one_reqs", req_count - base, 1);
    check("one_hold_valid", 32'(valid_out), 1);
    check("one_hold_data", 32'(data_out), 32'h A5);
    ready_in = 1'b1;
    adv(1);
    ready_in = 1'b0;
    check("one_after_xfer_valid", 32'(valid_out), 0);
    check("one_sb_empty", exp_q.size(), 0);

    // Three words streaming
    ready_in = 1'b1;
    base = req_count;
    load(8'h11);
    load(8'h22);
    load(8'h33);
    wait_drain("three_drain", 60);
    check("three_reqs", req_count - base, 3);
    if (req_count - base == 3) begin
      for (int i = 1; i < 3; i++) begin
        d = req_cyc[base + i] - req_cyc[base + i - 1];
        check("three_req_spacing", 32'(d == HOLDOFF || d == HOLDOFF + 1), 1);
      end
    end
    check("three_words", 32'(words_read), 4);
    check("three_len", 32'(len_in), 0);
    adv(10);
    check("three_no_extra_req", req_count - base, 3);

    // Two words with downstream stalled
    ready_in = 1'b0;
    base = req_count;
    load(8'h11);
    load(8'h22);
    adv(20);
`ifdef FILA_LEITOR_PREFETCH_EN
    check("stall_reqs", req_count - base, 2);
    check("stall_valid", 32'(valid_out), 1);
    check("stall_data", 32'(data_out), 32'h11);
    ready_in = 1'b1;
    adv(1);
    check("stall_promote_data", 32'(data_out), 32'h22);
    check("stall_promote_valid", 32'(valid_out), 1);
    adv(1);
    check("stall_empty_valid", 32'(valid_out), 0);
`else
    check("stall_reqs", req_count - base, 1);
    check("stall_valid", 32'(valid_out), 1);
    check("stall_data", 32'(data_out), 32'h11);
    ready_in = 1'b1;
    wait_drain("stall_drain", 40);
    check("stall_reqs_after", req_count - base, 2);
`endif
    check("stall_words", 32'(words_read), 6);
    check("stall_sb_empty", exp_q.size(), 0);

    // Reset while waiting on the queue
    ready_in = 1'b0;
    base = req_count;
    load(8'h77);
    adv(1);
    check("rstmid_c0_deq", 32'(dequeue_out), 1);
    adv(1);
    check("rstmid_c1_busy", 32'(busy_out), 1);
    reset  = 1'b1;
    len_in = 8'd0;
    qmem.delete();
    exp_q.delete();
    #1;
    check("rstmid_dequeue", 32'(dequeue_out), 0);
    check("rstmid_busy", 32'(busy_out), 0);
    check("rstmid_valid", 32'(valid_out), 0);
    check("rstmid_data", 32'(data_out), 0);
    check("rstmid_words", 32'(words_read), 0);
    adv(2);
    reset = 1'b0;
    adv(15);
    check("rstmid_reqs", req_count - base, 1);
    check("rstmid_valid_after", 32'(valid_out), 0);
    check("rstmid_words_after", 32'(words_read), 0);

    // Counter wrap over 256 captures
    ready_in = 1'b1;
    for (int b = 0; b < 32; b++) begin
      for (int i = 0; i < 8; i++) load(8'(b * 8 + i) ^ 8'h5A);
      wait_drain("wrap_drain", 100);
    end
    check("wrap_words_256", 32'(words_read), 0);
    load(8'hC3);
    wait_drain("wrap_drain_last", 30);
    check("wrap_words_257", 32'(words_read), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
